channel_scan_mux: RTL and testbench
===================================

CHANNEL_SCAN_MUX -- requirements
Module: channel_scan_mux

Interface
- REQ-001: Parameter NUM_CH, default 7, number of input channels; legal range 2..16.
- REQ-002: Parameter DATA_W, default 1, bit width of each channel.
- REQ-003: Parameter SCAN_DIV, default 4, clock cycles per scan step; legal range 1..65535.
- REQ-004: Derived constant SEL_W = clog2(NUM_CH), the select width; it is not user-settable.
- REQ-005: Port clock, input, 1, the single clock; all state updates on its rising edge.
- REQ-006: Port resetn, input, 1, reset; asynchronous assertion and deassertion, active-low.
- REQ-007: Port in_data, input, NUM_CH*DATA_W, packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- REQ-008: Port sel, input, SEL_W, channel select, used in manual mode.
- REQ-009: Port mode, input, 1, mode select: 0 = manual, 1 = scan.
- REQ-010: Port enable, input, 1, run enable; 0 forces the IDLE state.
- REQ-011: Port out_ready, input, 1, downstream accept.
- REQ-012: Port out_data, output, DATA_W, selected channel value (registered).
- REQ-013: Port out_chan, output, SEL_W, index of the channel held in out_data.
- REQ-014: Port out_valid, output, 1, out_data/out_chan hold a sample.
- REQ-015: Port sel_err, output, 1, registered flag: the last manual capture used sel >= NUM_CH.

Function
- REQ-016: FSM states are IDLE, MANUAL and SCAN. Transitions:
  - enable=0 -> IDLE.
  - enable=1 & mode=0 -> MANUAL.
  - enable=1 & mode=1 -> SCAN.
  - Each transition is evaluated every cycle.
- REQ-017: Output register is free when out_valid=0 or out_ready=1; no capture occurs otherwise, and out_data/out_chan stay stable while out_valid=1 & out_ready=0.
- REQ-018: In MANUAL, capture every free cycle (latency 1 cycle from sel/in_data to out_data):
  - out_data = channel sel, out_chan = sel, sel_err = 0.
  - If sel >= NUM_CH: out_data = 0, out_chan = sel, sel_err = 1.
- REQ-019: In SCAN, a divider counts 0..SCAN_DIV-1 and wraps. A step fires on the cycle the count equals SCAN_DIV-1.
- REQ-020: On a scan step with the register free:
  - Capture channel scan_ptr, set out_chan = scan_ptr.
  - Advance scan_ptr; it wraps from NUM_CH-1 to 0.
- REQ-021: A scan step with the register not free stalls. The divider holds at SCAN_DIV-1 and scan_ptr holds, so no channel is skipped.
- REQ-022: In SCAN, out_valid is set on capture and cleared on the cycle out_ready=1 with no new capture. A simultaneous accept and capture leaves out_valid=1 with the new sample.
- REQ-023: Entering SCAN from any other state clears the divider and scan_ptr to 0. The first capture occurs SCAN_DIV cycles after entry.
- REQ-024: In IDLE, no capture occurs. out_valid clears on accept; a pending sample is otherwise held. The divider and scan_ptr are cleared.
- REQ-025: A mode change while out_valid=1 & out_ready=0 keeps the held sample until accepted.

Reset
- REQ-026: While resetn=0:
  - out_data=0, out_chan=0, out_valid=0, sel_err=0.
  - Divider=0, scan_ptr=0, state=IDLE.
- REQ-027: Reset asserted mid-stall discards the held sample immediately, without waiting for a clock edge.

Configuration
- REQ-028: Macro CHANNEL_SCAN_MUX_SCAN_EN defined: SCAN state, divider and scan_ptr are present.
- REQ-029: Macro CHANNEL_SCAN_MUX_SCAN_EN undefined:
  - mode is ignored and enable=1 always selects MANUAL.
  - The divider and scan_ptr logic is absent.
  - All other requirements hold.

Structure
- REQ-030: Shared package channel_scan_pkg holds:
  - state enum (IDLE, MANUAL, SCAN);
  - mode constants MODE_MANUAL=0, MODE_SCAN=1;
  - limits NUM_CH_MAX=16, SCAN_DIV_MAX=65535.
- REQ-031: The divider is the sub-module rate_divider, with ports clock, resetn, clear, hold, and tick output.

Verification
- REQ-032: Manual: NUM_CH=7, DATA_W=1, in_data=7'b1010110, out_ready=1, sel=2 -> next cycle out_data=1, out_chan=2, out_valid=1, sel_err=0.
- REQ-033: Out-of-range select: sel=7 with NUM_CH=7 -> out_data=0, sel_err=1; then sel=3 -> sel_err=0.
- REQ-034: Scan: SCAN_DIV=4, out_ready=1, enable=1, mode=1 -> captures every 4 cycles of channels 0,1,...,6,0; first capture on the 4th cycle after entry.
- REQ-035: Backpressure: scan with out_ready=0 for 10 cycles -> out_data stable and scan_ptr frozen; on release the next capture is the next channel, none skipped.
- REQ-036: Reset mid-scan: resetn low for 2 cycles at scan_ptr=5 -> all outputs 0 asynchronously; after release with enable=1 & mode=1 the first capture is channel 0.
- REQ-037: Macro undefined: mode=1, enable=1, sel=4 -> behaves as manual, capturing channel 4.

Source files
------------

// File: rtl/channel_scan_pkg.sv
// rtl/channel_scan_pkg.sv - shared types and limits for the channel scan multiplexer
package channel_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int NUM_CH_MAX   = 16;
    localparam int SCAN_DIV_MAX = 65535;

    // Counter width for a divide-by-div counter; never narrower than one bit
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/channel_scan_mux_if.sv
// rtl/channel_scan_mux_if.sv - channel/select inputs and sampled output bundle
interface channel_scan_mux_if #(
    parameter int NUM_CH = 7,
    parameter int DATA_W = 1
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [SEL_W-1:0]         sel;
    logic                     mode;
    logic                     enable;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_chan;
    logic                     out_valid;
    logic                     sel_err;

    modport master (
        output in_data, sel, mode, enable, out_ready,
        input  out_data, out_chan, out_valid, sel_err
    );

    modport slave (
        input  in_data, sel, mode, enable, out_ready,
        output out_data, out_chan, out_valid, sel_err
    );
endinterface

// File: rtl/channel_scan_mux_rate_divider.sv
// rtl/channel_scan_mux_rate_divider.sv - scan step divider that can hold on its last count
module rate_divider
    import channel_scan_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic hold,
    output logic tick
);
    localparam int CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    // Count 0..DIV-1 and wrap; a held tick parks on the last count so the step is not lost
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            if (!hold) begin
                count <= '0;
            end
        end else begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/channel_scan_mux.sv
// rtl/channel_scan_mux.sv - manual/scan channel multiplexer with registered output; scan mode built when CHANNEL_SCAN_MUX_SCAN_EN is defined
module channel_scan_mux
    import channel_scan_pkg::*;
#(
    parameter int NUM_CH   = 7,
    parameter int DATA_W   = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic               clock,
    input  logic               resetn,
    channel_scan_mux_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_CH);

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  out_data_q;
    logic [SEL_W-1:0]   out_chan_q;
    logic               out_valid_q;
    logic               sel_err_q;
    logic               free;
    logic               cap_manual;
    logic               cap_scan;
    logic               sel_oob;
    logic [SEL_W-1:0]   pick;
    logic [DATA_W-1:0]  pick_data;

    assign free       = !out_valid_q || bus.out_ready;
    assign cap_manual = (state == MANUAL) && free;
    assign sel_oob    = 32'(bus.sel) >= NUM_CH;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state follows enable/mode every cycle
    always_comb begin
        state_next = IDLE;
        if (bus.enable) begin
`ifdef CHANNEL_SCAN_MUX_SCAN_EN
            state_next = (bus.mode == MODE_SCAN) ? SCAN : MANUAL;
`else
            state_next = MANUAL;
`endif
        end
    end

`ifdef CHANNEL_SCAN_MUX_SCAN_EN
    logic             tick;
    logic             div_clear;
    logic             div_hold;
    logic [SEL_W-1:0] scan_ptr;

    assign div_clear = (state != SCAN);
    assign div_hold  = !free;
    assign cap_scan  = (state == SCAN) && tick && free;
    assign pick      = (state == SCAN) ? scan_ptr : bus.sel;

    rate_divider #(.DIV(SCAN_DIV)) u_div (
        .clock  (clock),
        .resetn (resetn),
        .clear  (div_clear),
        .hold   (div_hold),
        .tick   (tick)
    );

    // Scan pointer restarts at channel 0 whenever scanning is (re)entered
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            scan_ptr <= '0;
        end else if (state != SCAN) begin
            scan_ptr <= '0;
        end else if (cap_scan) begin
            scan_ptr <= (scan_ptr == SEL_W'(NUM_CH - 1)) ? '0 : scan_ptr + SEL_W'(1);
        end
    end
`else
    assign cap_scan = 1'b0;
    assign pick     = bus.sel;
`endif

    // Channel mux; out-of-range indices read as zero
    always_comb begin
        pick_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (pick == SEL_W'(k)) begin
                pick_data = bus.in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Output register: capture when free, otherwise hold; drop valid on a bare accept
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else if (cap_manual) begin
            out_data_q  <= sel_oob ? '0 : pick_data;
            out_chan_q  <= bus.sel;
            out_valid_q <= 1'b1;
            sel_err_q   <= sel_oob;
        end else if (cap_scan) begin
            out_data_q  <= pick_data;
            out_chan_q  <= pick;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_channel_scan_mux.sv
// tb/tb_channel_scan_mux.sv - directed bench with a behavioural model for channel_scan_mux
module tb_channel_scan_mux;
    localparam int N   = 7;
    localparam int W   = 1;
    localparam int DIV = 4;
    localparam logic [N*W-1:0] PATTERN = 7'b1010110;

    logic clock;
    logic resetn;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_on = 0;

    channel_scan_mux_if #(.NUM_CH(N), .DATA_W(W)) bus ();

    channel_scan_mux #(.NUM_CH(N), .DATA_W(W), .SCAN_DIV(DIV)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Model: 0 idle, 1 manual, 2 scan; m_cnt counts cycles spent waiting in the current scan step
    int       m_state = 0;
    int       m_cnt = 0;
    int       m_ptr = 0;
    int       m_data = 0;
    int       m_chan = 0;
    int       m_valid = 0;
    int       m_err = 0;

    function automatic int chan_value(input logic [N*W-1:0] v, input int ch);
        return int'(v[ch*W +: W]);
    endfunction

    always @(negedge resetn) begin
        m_state = 0; m_cnt = 0; m_ptr = 0;
        m_data = 0; m_chan = 0; m_valid = 0; m_err = 0;
    end

    always @(posedge clock) begin
        if (resetn) begin
            bit cap;
            bit fr;
            int nxt;
            cap = 0;
            fr = (m_valid == 0) || bus.out_ready;
            if (m_state == 1 && fr) begin
                cap = 1;
                m_chan = int'(bus.sel);
                if (int'(bus.sel) >= N) begin
                    m_data = 0; m_err = 1;
                end else begin
                    m_data = chan_value(bus.in_data, int'(bus.sel)); m_err = 0;
                end
            end
            if (m_state == 2) begin
                if (m_cnt == DIV - 1) begin
                    if (fr) begin
                        cap = 1;
                        m_chan = m_ptr;
                        m_data = chan_value(bus.in_data, m_ptr);
                        m_ptr = (m_ptr + 1) % N;
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt++;
                end
            end
            if (cap) m_valid = 1;
            else if (bus.out_ready) m_valid = 0;
            nxt = 0;
            if (bus.enable) begin
`ifdef CHANNEL_SCAN_MUX_SCAN_EN
                nxt = bus.mode ? 2 : 1;
`else
                nxt = 1;
`endif
            end
            if (nxt != 2) begin
                m_cnt = 0; m_ptr = 0;
            end
            m_state = nxt;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (cmp_on) begin
            check("model out_data",  int'(bus.out_data),  m_data);
            check("model out_chan",  int'(bus.out_chan),  m_chan);
            check("model out_valid", int'(bus.out_valid), m_valid);
            check("model sel_err",   int'(bus.sel_err),   m_err);
        end
    end

    initial begin
        resetn        = 1'b0;
        bus.in_data   = PATTERN;
        bus.sel       = '0;
        bus.mode      = 1'b0;
        bus.enable    = 1'b0;
        bus.out_ready = 1'b1;
        step(); step();
        check("reset out_data",  int'(bus.out_data), 0);
        check("reset out_chan",  int'(bus.out_chan), 0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset sel_err",   int'(bus.sel_err), 0);
        cmp_on = 1;

        resetn = 1'b1;
        bus.enable = 1'b1;
        step(); step();
        bus.sel = 3'd2;
        step();
        check("manual sel2 data",  int'(bus.out_data), 1);
        check("manual sel2 chan",  int'(bus.out_chan), 2);
        check("manual sel2 valid", int'(bus.out_valid), 1);
        check("manual sel2 err",   int'(bus.sel_err), 0);

        bus.sel = 3'd7;
        step();
        check("oob sel7 data", int'(bus.out_data), 0);
        check("oob sel7 chan", int'(bus.out_chan), 7);
        check("oob sel7 err",  int'(bus.sel_err), 1);
        bus.sel = 3'd3;
        step();
        check("sel3 data", int'(bus.out_data), 0);
        check("sel3 err",  int'(bus.sel_err), 0);
        bus.sel = 3'd6;
        step();
        check("sel6 data", int'(bus.out_data), 1);

        bus.sel = 3'd4;
        step();
        bus.out_ready = 1'b0;
        bus.sel = 3'd1;
        step(); step();
        check("manual stall chan", int'(bus.out_chan), 4);
        bus.out_ready = 1'b1;
        step();
        check("manual release chan", int'(bus.out_chan), 1);
        check("manual release data", int'(bus.out_data), 1);

`ifndef CHANNEL_SCAN_MUX_SCAN_EN
        bus.mode = 1'b1;
        bus.sel = 3'd4;
        step();
        check("mode ignored chan",  int'(bus.out_chan), 4);
        check("mode ignored data",  int'(bus.out_data), 1);
        check("mode ignored valid", int'(bus.out_valid), 1);
        bus.mode = 1'b0;
`endif

        bus.enable = 1'b0;
        step(); step();
        check("idle valid cleared", int'(bus.out_valid), 0);

`ifdef CHANNEL_SCAN_MUX_SCAN_EN
        bus.enable = 1'b1;
        bus.mode = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            repeat (4) step();
            check("scan chan",  int'(bus.out_chan), i % N);
            check("scan data",  int'(bus.out_data), int'(PATTERN[i % N]));
            check("scan valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b0;
        repeat (10) step();
        check("stall chan",  int'(bus.out_chan), 0);
        check("stall data",  int'(bus.out_data), 0);
        check("stall valid", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        step();
        check("after stall chan", int'(bus.out_chan), 1);
        for (int i = 2; i < 5; i++) begin
            repeat (4) step();
            check("scan resume chan", int'(bus.out_chan), i);
        end
        #3 resetn = 1'b0;
        #1;
        check("async reset data",  int'(bus.out_data), 0);
        check("async reset chan",  int'(bus.out_chan), 0);
        check("async reset valid", int'(bus.out_valid), 0);
        check("async reset err",   int'(bus.sel_err), 0);
        step(); step();
        resetn = 1'b1;
        repeat (5) step();
        check("post reset chan",  int'(bus.out_chan), 0);
        check("post reset valid", int'(bus.out_valid), 1);
`endif

        step();
        cmp_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
